rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
Registered RV32I instruction decode stage with optional M-extension decoding, sitting between fetch and register-read/ALU.
- Accepts one instruction and PC per cycle over a valid/ready handshake.
- Produces fully decoded fields, a sign-extended immediate, an encoded ALU op, a one-hot class vector and an illegal-instruction flag.
- A two-entry skid buffer sustains full throughput under backpressure.

Parameters:
XLEN, 32, width of out_imm and out_pc; legal values 32 or 64; immediates are sign-extended to XLEN.
EN_M, 0, 1 = decode OP/funct7=0000001 as MUL..REMU; 0 = flag those encodings illegal.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops all buffered entries
in_valid  in  1  in_instr/in_pc valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded entry valid
out_ready  in  1  consumer accepts
out_pc  out  XLEN  PC of decoded instruction
out_rs1, out_rs2, out_rd  out  5 each  register indices; 0 when unused
out_rs1_used, out_rs2_used  out  1 each  operand read required
out_rd_we  out  1  writeback required (rd used and rd!=0)
out_funct3  out  3  raw funct3 (load/store size, branch condition)
out_imm  out  XLEN  sign-extended immediate; 0 for R-type
out_alu_op  out  5  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB,11 MUL,12 MULH,13 MULHSU,14 MULHU,15 DIV,16 DIVU,17 REM,18 REMU
out_class  out  11  one-hot: [0]OP [1]OPIMM [2]LOAD [3]STORE [4]BRANCH [5]JAL [6]JALR [7]LUI [8]AUIPC [9]SYSTEM [10]MULDIV
out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (rst_n low, async): both entries invalid; out_valid=0, in_ready=1; all data outputs 0.
- Decode is combinational on in_instr. The result is captured into the main entry on accept (in_valid & in_ready).
- Latency: 1 cycle from accept to out_valid. Throughput: 1/cycle while out_ready=1.
- Skid buffer:
  - in_ready = !skid_valid, registered.
  - Accept while main is valid and not consumed: the entry goes to skid.
  - Main is consumed (out_valid & out_ready): skid moves to main if valid, else main loads the incoming accept, else main goes invalid.
  - Order is always preserved.
- Simultaneous consume and accept with skid empty: main reloads from input; no bubble.
- flush: clears both valid bits next edge; any same-cycle input is dropped; in_ready=1 the following cycle. flush has priority over accept.
- Immediates:
  - I = instr[31:20], S = {[31:25],[11:7]}, B = {[31],[7],[30:25],[11:8],0}, J = {[31],[19:12],[20],[30:21],0}, U = {[31:12],12'b0}.
  - All are sign-extended from instr[31] to XLEN.
- ALU op:
  - OP: funct7/funct3 select the op; SUB/SRA when funct7=0100000.
  - OPIMM: funct3 selects the op; SRAI when instr[31:25]=0100000; never SUB.
  - LOAD, STORE, JALR, AUIPC: ADD. LUI: PASSB. BRANCH: SUB. JAL: ADD.
- Field use:
  - rs1_used: OP, OPIMM, LOAD, STORE, BRANCH, JALR, MULDIV.
  - rs2_used: OP, STORE, BRANCH, MULDIV.
  - rd used: all except STORE, BRANCH, SYSTEM.
  - Unused index outputs are forced to 0.
- Illegal when any of the following holds:
  - instr[1:0]!=11, or opcode unknown;
  - OP funct7 not in {0000000, 0100000 (funct3 000/101 only)}, with 0000001 allowed only if EN_M=1;
  - OPIMM shift with an invalid funct7;
  - LOAD funct3 in {011,110,111}; STORE funct3>010; BRANCH funct3 in {010,011}; JALR funct3!=0;
  - SYSTEM not exactly 0x00000073 or 0x00100073.
- On illegal: out_class=0, out_rd_we=0, rs*_used=0, out_alu_op=0. The entry still flows through the handshake.
- Data outputs hold while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi x1,x0,-1) -> next cycle: out_valid=1, class[1]=1, rd=1, rd_we=1, imm=0xFFFFFFFF, alu_op=0.
- 0x402081B3 (sub x3,x1,x2) then 0xFE208EE3 (beq x1,x2,-4) back-to-back:
  - sub: alu_op=1, rs1=1, rs2=2.
  - beq: class[4]=1, imm=0xFFFFFFFC, rd_we=0.
- 0x123452B7 (lui x5,0x12345) with XLEN=64 -> imm=0x0000000012345000, alu_op=10, rs1_used=0.
- 0x023100B3 (mul x1,x2,x3):
  - EN_M=0 -> out_illegal=1, class=0.
  - EN_M=1 -> class[10]=1, alu_op=11.
- Hold out_ready=0 and stream 3 instructions:
  - Two are accepted; in_ready drops after the 2nd.
  - After releasing out_ready, all 3 emerge in order with no duplicate.
- With 2 entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and input entries never appear.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I (+ optional M) decode stage: combinational decode of the incoming word,
// captured into a two-entry skid buffer so the stage streams at one instruction per cycle.
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic [10:0]     out_class,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd11;

  localparam int CLS_OP     = 0;
  localparam int CLS_OPIMM  = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;
  localparam int CLS_SYSTEM = 9;
  localparam int CLS_MULDIV = 10;

  // Which classes read rs1 / read rs2 / write rd
  localparam logic [10:0] RS1_MASK = 11'h45F;
  localparam logic [10:0] RS2_MASK = 11'h419;
  localparam logic [10:0] RD_MASK  = 11'h5E7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1Used;
    logic            rs2Used;
    logic            rdWe;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [4:0]      aluOp;
    logic [10:0]     cls;
    logic            illegal;
  } entry_t;

  function automatic logic [4:0] baseAluOp(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  baseAluOp = alt ? ALU_SUB : ALU_ADD;
      3'b001:  baseAluOp = ALU_SLL;
      3'b010:  baseAluOp = ALU_SLT;
      3'b011:  baseAluOp = ALU_SLTU;
      3'b100:  baseAluOp = ALU_XOR;
      3'b101:  baseAluOp = alt ? ALU_SRA : ALU_SRL;
      3'b110:  baseAluOp = ALU_OR;
      default: baseAluOp = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI, immS, immB, immJ, immU;
  logic        shiftHiZero, shiftHiSra;
  logic [10:0] decClass;
  logic [4:0]  decAluOp;
  logic [31:0] decImm32;
  logic        decIllegal;
  logic        rdUsed;
  entry_t      decEntry;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign immI   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign immS   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign immB   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign immJ   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign immU   = {in_instr[31:12], 12'b0};

  // RV64 shift amounts are 6 bits, so the funct field above them shrinks to 6 bits
  assign shiftHiZero = (XLEN == 64) ? (in_instr[31:26] == 6'b000000) : (funct7 == 7'b0000000);
  assign shiftHiSra  = (XLEN == 64) ? (in_instr[31:26] == 6'b010000) : (funct7 == 7'b0100000);

  always_comb begin
    decClass   = '0;
    decAluOp   = ALU_ADD;
    decImm32   = '0;
    decIllegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      decIllegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          if (funct7 == 7'b0000000) begin
            decClass[CLS_OP] = 1'b1;
            decAluOp = baseAluOp(funct3, 1'b0);
          end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
            decClass[CLS_OP] = 1'b1;
            decAluOp = baseAluOp(funct3, 1'b1);
          end else if (funct7 == 7'b0000001 && EN_M) begin
            decClass[CLS_MULDIV] = 1'b1;
            decAluOp = ALU_MUL + {2'b00, funct3};
          end else begin
            decIllegal = 1'b1;
          end
        end
        OPC_OPIMM: begin
          decClass[CLS_OPIMM] = 1'b1;
          decImm32 = immI;
          decAluOp = baseAluOp(funct3, 1'b0);
          if (funct3 == 3'b001 && !shiftHiZero) decIllegal = 1'b1;
          if (funct3 == 3'b101) begin
            if (shiftHiSra) decAluOp = ALU_SRA;
            else if (!shiftHiZero) decIllegal = 1'b1;
          end
        end
        OPC_LOAD: begin
          decClass[CLS_LOAD] = 1'b1;
          decImm32 = immI;
          if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) decIllegal = 1'b1;
        end
        OPC_STORE: begin
          decClass[CLS_STORE] = 1'b1;
          decImm32 = immS;
          if (funct3 > 3'b010) decIllegal = 1'b1;
        end
        OPC_BRANCH: begin
          decClass[CLS_BRANCH] = 1'b1;
          decImm32 = immB;
          decAluOp = ALU_SUB;
          if (funct3 == 3'b010 || funct3 == 3'b011) decIllegal = 1'b1;
        end
        OPC_JAL: begin
          decClass[CLS_JAL] = 1'b1;
          decImm32 = immJ;
        end
        OPC_JALR: begin
          decClass[CLS_JALR] = 1'b1;
          decImm32 = immI;
          if (funct3 != 3'b000) decIllegal = 1'b1;
        end
        OPC_LUI: begin
          decClass[CLS_LUI] = 1'b1;
          decImm32 = immU;
          decAluOp = ALU_PASSB;
        end
        OPC_AUIPC: begin
          decClass[CLS_AUIPC] = 1'b1;
          decImm32 = immU;
        end
        OPC_SYSTEM: begin
          decClass[CLS_SYSTEM] = 1'b1;
          decImm32 = immI;
          if (in_instr != 32'h0000_0073 && in_instr != 32'h0010_0073) decIllegal = 1'b1;
        end
        default: decIllegal = 1'b1;
      endcase
    end
    // An illegal word carries no class, so all operand/writeback qualifiers fall to zero
    if (decIllegal) begin
      decClass = '0;
      decAluOp = ALU_ADD;
      decImm32 = '0;
    end
  end

  assign rdUsed = |(decClass & RD_MASK);

  always_comb begin
    decEntry         = '0;
    decEntry.pc      = in_pc;
    decEntry.rs1Used = |(decClass & RS1_MASK);
    decEntry.rs2Used = |(decClass & RS2_MASK);
    decEntry.rs1     = decEntry.rs1Used ? in_instr[19:15] : 5'd0;
    decEntry.rs2     = decEntry.rs2Used ? in_instr[24:20] : 5'd0;
    decEntry.rd      = rdUsed ? in_instr[11:7] : 5'd0;
    decEntry.rdWe    = rdUsed && (in_instr[11:7] != 5'd0);
    decEntry.funct3  = funct3;
    decEntry.imm     = XLEN'($signed(decImm32));
    decEntry.aluOp   = decAluOp;
    decEntry.cls     = decClass;
    decEntry.illegal = decIllegal;
  end

  entry_t main_q, main_d, skid_q, skid_d;
  logic   mainVld_q, mainVld_d, skidVld_q, skidVld_d;
  logic   accept, consume;

  assign in_ready = !skidVld_q;
  assign accept   = in_valid && in_ready;
  assign consume  = mainVld_q && out_ready;

  // Skid only fills while main is stalled, and drains into main before new input does
  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    mainVld_d = mainVld_q;
    skidVld_d = skidVld_q;
    if (flush) begin
      mainVld_d = 1'b0;
      skidVld_d = 1'b0;
    end else if (!mainVld_q || consume) begin
      if (skidVld_q) begin
        main_d    = skid_q;
        mainVld_d = 1'b1;
        skidVld_d = 1'b0;
      end else if (accept) begin
        main_d    = decEntry;
        mainVld_d = 1'b1;
      end else begin
        mainVld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d    = decEntry;
      skidVld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      skid_q    <= '0;
      mainVld_q <= 1'b0;
      skidVld_q <= 1'b0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      mainVld_q <= mainVld_d;
      skidVld_q <= skidVld_d;
    end
  end

  assign out_valid    = mainVld_q;
  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_rs1_used = main_q.rs1Used;
  assign out_rs2_used = main_q.rs2Used;
  assign out_rd_we    = main_q.rdWe;
  assign out_funct3   = main_q.funct3;
  assign out_imm      = main_q.imm;
  assign out_alu_op   = main_q.aluOp;
  assign out_class    = main_q.cls;
  assign out_illegal  = main_q.illegal;

endmodule
